// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline stall/flush controller with memory-wait watchdog and perf counters
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_TIMEOUT
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic mem_wait;
    logic flush_event;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));
    assign mem_wait = dmem_req && !dmem_ready;

    // Branch is held in EX during a memory wait, so it only counts once applied.
    assign flush_event = !mem_wait && (branch_taken || load_use);

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_stall  = 1'b0;
        mem_wb_bubble = 1'b0;
        if (mem_wait) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            S_RUN: begin
                if (mem_wait) begin
                    state_d    = S_MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            S_MEM_WAIT: begin
                if (!mem_wait) begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d       = S_TIMEOUT;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            S_TIMEOUT: begin
                if (!mem_wait) begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = S_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_event && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 64: the number of consecutive memory-wait cycles that raises the timeout flag.
REQ-002 Parameter CNT_W, default 16: the width of each performance counter.
REQ-003 clk  in  1  is the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  is the reset: asynchronous, active-low.
REQ-005 id_rs1, id_rs2  in  5 each  are the source registers of the instruction in ID.
REQ-006 id_uses_rs1, id_uses_rs2  in  1 each  flag that the ID instruction actually reads the matching source.
REQ-007 ex_rd  in  5  is the destination register of the instruction in EX.
REQ-008 ex_mem_read  in  1  flags that the EX instruction is a load.
REQ-009 branch_taken  in  1  flags a branch or jump resolved taken in EX.
REQ-010 imem_ready  in  1  flags that instruction fetch data is valid this cycle.
REQ-011 dmem_req  in  1  flags that the MEM stage has an access outstanding.
REQ-012 dmem_ready  in  1  flags that the data memory completes the access this cycle.
REQ-013 pc_write  out  1  is the PC update enable.
REQ-014 if_id_write  out  1  is the IF/ID load enable.
REQ-015 if_id_flush  out  1  clears IF/ID to a bubble.
REQ-016 id_ex_stall  out  1  holds ID/EX.
REQ-017 id_ex_flush  out  1  clears ID/EX to a bubble.
REQ-018 ex_mem_stall  out  1  holds EX/MEM.
REQ-019 mem_wb_bubble  out  1  loads a bubble into MEM/WB.
REQ-020 mem_timeout  out  1  is a sticky error flag.
REQ-021 stall_cnt  out  CNT_W  counts stall cycles.
REQ-022 flush_cnt  out  CNT_W  counts flush events.

Function
REQ-023 All control outputs are combinational from inputs and FSM state; counters and FSM are registered.
REQ-024 Default (no hazard): pc_write=1, if_id_write=1, and every stall, flush and bubble output is 0.
REQ-025 load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-026 mem_wait = dmem_req & !dmem_ready.
REQ-027 Priority, highest first: mem_wait, branch_taken, load_use, !imem_ready.
REQ-028 On mem_wait, the controller asserts pc_write=0, if_id_write=0, id_ex_stall=1, ex_mem_stall=1 and mem_wb_bubble=1.
REQ-029 During mem_wait, all flushes are 0; a pending branch_taken stays held in EX and takes effect on the first cycle with no wait.
REQ-030 On branch_taken without wait, the controller asserts pc_write=1, if_id_flush=1 and id_ex_flush=1.
REQ-031 On load_use without wait or branch, the controller asserts pc_write=0, if_id_write=0 and id_ex_flush=1 (a one-cycle bubble).
REQ-032 Load_use deasserts naturally the next cycle, when the load reaches MEM.
REQ-033 On !imem_ready alone, the controller asserts pc_write=0, if_id_write=1 and if_id_flush=1, so a bubble enters IF/ID.
REQ-034 id_ex_stall and id_ex_flush are never both 1 in the same cycle.
REQ-035 if_id_write and if_id_flush may both be 1; IF/ID gives flush priority.
REQ-036 FSM states are RUN, MEM_WAIT and TIMEOUT.
REQ-037 RUN moves to MEM_WAIT when mem_wait is true; wait_cnt is loaded with 1.
REQ-038 In MEM_WAIT, when mem_wait is true, wait_cnt increments; when wait_cnt==MEM_TIMEOUT-1 the FSM moves to TIMEOUT and mem_timeout is set.
REQ-039 MEM_WAIT returns to RUN when mem_wait is false.
REQ-040 TIMEOUT returns to RUN when mem_wait is false; mem_timeout stays 1 until reset.
REQ-041 Output freezing depends only on mem_wait, not on FSM state.
REQ-042 stall_cnt increments on every cycle with pc_write=0, and saturates at all-ones.
REQ-043 flush_cnt increments on every cycle with branch_taken applied or load_use applied, and saturates at all-ones.

Reset
REQ-044 While rst_n=0: FSM=RUN, wait_cnt=0, mem_timeout=0, stall_cnt=0 and flush_cnt=0.
REQ-045 Combinational outputs follow REQ-024 during reset, given benign inputs.
REQ-046 Reset asserted mid-wait aborts MEM_WAIT or TIMEOUT immediately.

Verification
REQ-047 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1; flush_cnt=1 and stall_cnt=1.
REQ-048 x0 case: same stimulus with ex_rd=0 -> default outputs; counters unchanged.
REQ-049 Branch over load-use: branch_taken=1 together with load_use -> pc_write=1, if_id_flush=1, id_ex_flush=1.
REQ-050 Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles with branch_taken=1 -> freeze outputs and no flush for 3 cycles; the branch flush appears in cycle 4; stall_cnt=3.
REQ-051 Timeout: with MEM_TIMEOUT=4, hold mem_wait for 6 cycles -> mem_timeout=1 after the 4th cycle; it stays 1 after dmem_ready, and clears only on rst_n=0.
REQ-052 Saturation: CNT_W=2, 5 stall cycles -> stall_cnt=3.
